// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and widths for the register-bank write-back path.
//   DATA_W    - register data width
//   ADDR_W    - register address width (32 registers)
//   wb_req_t  - one queued write {dest, data}
//   wb_src_e  - write-back requester, used as the round-robin pointer
package regfile_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MAC = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t entries, one per write-back requester.
//   clk, rst  - clock, synchronous active-high reset (empties the FIFO)
//   push      - write push_req (caller guarantees !full)
//   pop       - drop the head entry (caller guarantees !empty)
//   pop_req   - current head entry
//   full      - DEPTH entries held (registered state only)
//   empty     - no entries held
// DEPTH must be a power of two, at least 2.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  wb_req_t push_req,
    input  logic    pop,
    output wb_req_t pop_req,
    output logic    full,
    output logic    empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    wb_req_t        mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_req;
        end
    end

    assign pop_req = mem[rd_ptr[PTR_W-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges ALU and MAC write-back streams onto the single
// register-bank write port, round-robin, one write per cycle.
//   clk, rst                       - clock, synchronous active-high reset
//   alu_valid/ready/dest/data      - ALU write request handshake
//   mac_valid/ready/dest/data      - MAC write request handshake
//   rf_write, rf_dest, rf_wr_data  - registered register-bank write port
//   query_src1/2, src1/2_busy      - pending-write lookup for issue stalls
// Optional feature macro: REGFILE_WB_SCOREBOARD_EN builds per-register
// pending-write counters; without it src1_busy/src2_busy are tied low.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mac_valid,
    output logic              mac_ready,
    input  logic [ADDR_W-1:0] mac_dest,
    input  logic [DATA_W-1:0] mac_data,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_dest,
    output logic [DATA_W-1:0] rf_wr_data,
    input  logic [ADDR_W-1:0] query_src1,
    input  logic [ADDR_W-1:0] query_src2,
    output logic              src1_busy,
    output logic              src2_busy
);

    logic    alu_full, alu_empty, alu_push, alu_pop;
    logic    mac_full, mac_empty, mac_push, mac_pop;
    wb_req_t alu_req, alu_head;
    wb_req_t mac_req, mac_head;
    wb_src_e rr_q, rr_d;

    // Ready comes from registered FIFO state only, so a same-cycle pop on a
    // full FIFO raises it one cycle later.
    assign alu_ready = !alu_full && !rst;
    assign mac_ready = !mac_full && !rst;
    assign alu_push  = alu_valid && alu_ready;
    assign mac_push  = mac_valid && mac_ready;
    assign alu_req   = '{dest: alu_dest, data: alu_data};
    assign mac_req   = '{dest: mac_dest, data: mac_data};

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (alu_push),
        .push_req (alu_req),
        .pop      (alu_pop),
        .pop_req  (alu_head),
        .full     (alu_full),
        .empty    (alu_empty)
    );

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_mac_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (mac_push),
        .push_req (mac_req),
        .pop      (mac_pop),
        .pop_req  (mac_head),
        .full     (mac_full),
        .empty    (mac_empty)
    );

    // Pointer only advances on contention, so a lone requester never
    // steals the other's next turn.
    always_comb begin
        alu_pop = 1'b0;
        mac_pop = 1'b0;
        rr_d    = rr_q;
        if (!alu_empty && !mac_empty) begin
            if (rr_q == WB_SRC_ALU) begin
                alu_pop = 1'b1;
                rr_d    = WB_SRC_MAC;
            end else begin
                mac_pop = 1'b1;
                rr_d    = WB_SRC_ALU;
            end
        end else if (!alu_empty) begin
            alu_pop = 1'b1;
        end else if (!mac_empty) begin
            mac_pop = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= WB_SRC_ALU;
            rf_write   <= 1'b0;
            rf_dest    <= '0;
            rf_wr_data <= '0;
        end else begin
            rr_q     <= rr_d;
            rf_write <= alu_pop || mac_pop;
            if (alu_pop) begin
                rf_dest    <= alu_head.dest;
                rf_wr_data <= alu_head.data;
            end else if (mac_pop) begin
                rf_dest    <= mac_head.dest;
                rf_wr_data <= mac_head.data;
            end
        end
    end

`ifdef REGFILE_WB_SCOREBOARD_EN
    localparam int unsigned CNT_W = $clog2(2*FIFO_DEPTH+2);
    localparam int unsigned NREG  = 1 << ADDR_W;

    logic [CNT_W-1:0] pend_cnt [NREG];

    // A write is pending from acceptance until the end of its rf_write
    // cycle; both requesters may hit the same register in one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NREG; i++) begin
                pend_cnt[i] <= pend_cnt[i]
                             + CNT_W'(alu_push && (alu_dest == ADDR_W'(i)))
                             + CNT_W'(mac_push && (mac_dest == ADDR_W'(i)))
                             - CNT_W'(rf_write && (rf_dest  == ADDR_W'(i)));
            end
        end
    end

    assign src1_busy = (pend_cnt[query_src1] != '0);
    assign src2_busy = (pend_cnt[query_src2] != '0);
`else
    logic unused_query;
    assign unused_query = ^{query_src1, query_src2};
    assign src1_busy    = 1'b0;
    assign src2_busy    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized checks of the write-back
// arbiter against a queue-based reference model of its behaviour.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_dest;
    logic [31:0] alu_data;
    logic        mac_valid, mac_ready;
    logic [4:0]  mac_dest;
    logic [31:0] mac_data;
    logic        rf_write;
    logic [4:0]  rf_dest;
    logic [31:0] rf_wr_data;
    logic [4:0]  query_src1, query_src2;
    logic        src1_busy, src2_busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_dest   (alu_dest),
        .alu_data   (alu_data),
        .mac_valid  (mac_valid),
        .mac_ready  (mac_ready),
        .mac_dest   (mac_dest),
        .mac_data   (mac_data),
        .rf_write   (rf_write),
        .rf_dest    (rf_dest),
        .rf_wr_data (rf_wr_data),
        .query_src1 (query_src1),
        .query_src2 (query_src2),
        .src1_busy  (src1_busy),
        .src2_busy  (src2_busy)
    );

    typedef struct {
        logic [4:0]  d;
        logic [31:0] x;
    } req_t;

    // Requests each source still wants to send, in order.
    req_t alu_src[$];
    req_t mac_src[$];
    // Reference model: entries waiting per source, pointer, output port.
    req_t m_alu[$];
    req_t m_mac[$];
    bit          m_rr_mac;
    logic        m_wr;
    logic [4:0]  m_dest;
    logic [31:0] m_data;

    logic [4:0]  q1, q2;
    bit          log_en;
    logic [31:0] obs[$];

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Writes still in flight to q: waiting in either queue or on the port now.
    function automatic int pending(input logic [4:0] q);
        int n = 0;
        foreach (m_alu[i]) if (m_alu[i].d == q) n++;
        foreach (m_mac[i]) if (m_mac[i].d == q) n++;
        if (m_wr && m_dest == q) n++;
        return n;
    endfunction

    function automatic logic exp_busy(input logic [4:0] q);
`ifdef REGFILE_WB_SCOREBOARD_EN
        return pending(q) != 0;
`else
        return (q === 5'bx);
`endif
    endfunction

    function automatic req_t rnd_req(input int max_dest);
        req_t r;
        r.d = 5'($urandom_range(0, max_dest));
        r.x = $urandom;
        return r;
    endfunction

    // One clock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input bit r);
        req_t pa, pm, popped;
        bit   va, vm, ra, rm, did_pop;
        va = (alu_src.size() != 0);
        vm = (mac_src.size() != 0);
        pa = va ? alu_src[0] : rnd_req(31);
        pm = vm ? mac_src[0] : rnd_req(31);
        alu_valid  = va;
        alu_dest   = pa.d;
        alu_data   = pa.x;
        mac_valid  = vm;
        mac_dest   = pm.d;
        mac_data   = pm.x;
        rst        = r;
        query_src1 = q1;
        query_src2 = q2;
        #1;
        ra = !r && (m_alu.size() < DEPTH);
        rm = !r && (m_mac.size() < DEPTH);
        check_eq("alu_ready",  alu_ready,  ra);
        check_eq("mac_ready",  mac_ready,  rm);
        check_eq("rf_write",   rf_write,   m_wr);
        check_eq("rf_dest",    rf_dest,    m_dest);
        check_eq("rf_wr_data", rf_wr_data, m_data);
        check_eq("src1_busy",  src1_busy,  exp_busy(q1));
        check_eq("src2_busy",  src2_busy,  exp_busy(q2));
        if (log_en && rf_write === 1'b1) obs.push_back(rf_wr_data);

        if (r) begin
            m_alu.delete();
            m_mac.delete();
            m_rr_mac = 1'b0;
            m_wr     = 1'b0;
            m_dest   = '0;
            m_data   = '0;
        end else begin
            did_pop = 1'b1;
            if (m_alu.size() != 0 && m_mac.size() != 0) begin
                popped   = m_rr_mac ? m_mac.pop_front() : m_alu.pop_front();
                m_rr_mac = !m_rr_mac;
            end else if (m_alu.size() != 0) begin
                popped = m_alu.pop_front();
            end else if (m_mac.size() != 0) begin
                popped = m_mac.pop_front();
            end else begin
                did_pop = 1'b0;
            end
            m_wr = did_pop;
            if (did_pop) begin
                m_dest = popped.d;
                m_data = popped.x;
            end
            if (va && ra) begin
                m_alu.push_back(pa);
                void'(alu_src.pop_front());
            end
            if (vm && rm) begin
                m_mac.push_back(pm);
                void'(mac_src.pop_front());
            end
        end
        @(negedge clk);
    endtask

    initial begin
        req_t t;
        rst       = 1'b1;
        alu_valid = 1'b0;
        mac_valid = 1'b0;
        alu_dest  = '0;
        alu_data  = '0;
        mac_dest  = '0;
        mac_data  = '0;
        q1        = '0;
        q2        = '0;
        log_en    = 1'b0;
        m_rr_mac  = 1'b0;
        m_wr      = 1'b0;
        m_dest    = '0;
        m_data    = '0;
        query_src1 = '0;
        query_src2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset values, then ready the first cycle after reset falls.
        step(1'b1);
        step(1'b0);

        // Single ALU write, 2-edge latency, one cycle of rf_write.
        q1 = 5'd3;
        t  = '{5'd3, 32'hDEADBEEF};
        alu_src.push_back(t);
        repeat (5) step(1'b0);

        // Both stream 4 requests from reset: strict alternation A,M,A,M...
        step(1'b1);
        for (int i = 0; i < 4; i++) begin
            t = '{5'(i), 32'hA000_0000 + 32'(i)};
            alu_src.push_back(t);
            t = '{5'(i + 8), 32'hB000_0000 + 32'(i)};
            mac_src.push_back(t);
        end
        log_en = 1'b1;
        repeat (14) step(1'b0);
        log_en = 1'b0;
        check_eq("stream_count", obs.size(), 8);
        for (int i = 0; i < 8 && i < obs.size(); i++) begin
            check_eq("stream_order", obs[i],
                     (i % 2 == 0) ? 32'hA000_0000 + 32'(i / 2) : 32'hB000_0000 + 32'(i / 2));
        end

        // MAC alone keeps pace with the port; then ALU joins and both fill.
        step(1'b1);
        for (int i = 0; i < 8; i++) mac_src.push_back(rnd_req(31));
        repeat (10) step(1'b0);
        for (int i = 0; i < 6; i++) begin
            alu_src.push_back(rnd_req(31));
            mac_src.push_back(rnd_req(31));
        end
        repeat (20) step(1'b0);

        // Same destination from both sources in one edge.
        step(1'b1);
        q1 = 5'd7;
        q2 = 5'd8;
        t  = '{5'd7, 32'h1111_1111};
        alu_src.push_back(t);
        t  = '{5'd7, 32'h2222_2222};
        mac_src.push_back(t);
        repeat (6) step(1'b0);

        // Reset while entries are queued: they are never written.
        t = '{5'd9, 32'h3333_3333};
        alu_src.push_back(t);
        t = '{5'd10, 32'h4444_4444};
        mac_src.push_back(t);
        step(1'b0);
        step(1'b1);
        alu_src.delete();
        mac_src.delete();
        repeat (4) step(1'b0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            if (alu_src.size() < 3 && $urandom_range(0, 99) < 60) alu_src.push_back(rnd_req(7));
            if (mac_src.size() < 3 && $urandom_range(0, 99) < 60) mac_src.push_back(rnd_req(7));
            q1 = 5'($urandom_range(0, 7));
            q2 = 5'($urandom_range(0, 31));
            step($urandom_range(0, 59) == 0);
        end
        alu_src.delete();
        mac_src.delete();
        repeat (6) step(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
